// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch stage between decode and the
// ALU / MEM / BR issue queues.
package dispatch_pkg;

  localparam int ROB_DEPTH_DEFAULT = 16;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Decoded instruction bundle as produced by the decoder, plus its pc.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fu_alu;
    logic        fu_mem;
    logic        fu_br;
    logic [31:0] pc;
  } dec_bundle_t;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_MEM  = 2'd2,
    FU_BR   = 2'd3
  } fu_class_e;

  // Stores and branches also carry fu_alu (address / compare work), so the
  // more specific unit wins: MEM first, then BR, then plain ALU.
  function automatic fu_class_e classify(input dec_bundle_t b);
    fu_class_e c;
    if (b.fu_mem)      c = FU_MEM;
    else if (b.fu_br)  c = FU_BR;
    else if (b.fu_alu) c = FU_ALU;
    else               c = FU_NONE;
    return c;
  endfunction

endpackage

// File: rtl/dispatch_fifo2.sv
// Two-entry circular buffer holding decoded bundles ahead of dispatch.
// The head entry is always visible on head_data; flush empties it at once.
module dispatch_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         head_q, head_d;
  logic         tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  // Next-state for storage, pointers and occupancy; flush overrides everything.
  always_comb begin
    do_push = push && (count_q != 2'd2);
    do_pop  = pop && (count_q != 2'd0);
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = ~tail_q;
      end
      if (do_pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // State registers; reset drops any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/dispatch_router.sv
// Routes the head of a 2-entry decode buffer to exactly one of the ALU, MEM
// or BR issue queues, stamping it with the current ROB tag. Entries with no
// FU flag are dropped with a one-cycle illegal pulse and consume no tag.
module dispatch_router
  import dispatch_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  dec_bundle_t       in_bundle,
  input  logic              rob_ready,
  output logic              alu_valid,
  output logic              mem_valid,
  output logic              br_valid,
  input  logic              alu_ready,
  input  logic              mem_ready,
  input  logic              br_ready,
  output dec_bundle_t       out_bundle,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              flush,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              illegal
);

  localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(ROB_DEPTH - 1);

  logic [$bits(dec_bundle_t)-1:0] head_raw;
  dec_bundle_t      head_bundle;
  logic [1:0]       fifo_count;
  fu_class_e        head_class;
  logic             has_head;
  logic             dispatch_ok;
  logic             push;
  logic             pop;
  logic             fire;
  logic             drop;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             illegal_q, illegal_d;
  logic             alive_q, alive_d;

  dispatch_fifo2 #(
    .W ($bits(dec_bundle_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_bundle),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_raw),
    .count     (fifo_count)
  );

  assign head_bundle = dec_bundle_t'(head_raw);
  assign head_class  = classify(head_bundle);
  assign has_head    = (fifo_count != 2'd0);

  // alive_q keeps in_ready low while reset is held; in_ready depends only on
  // registered state and flush, never on the downstream ready signals.
  assign in_ready = alive_q && (fifo_count != 2'd2) && !flush;
  assign push     = in_valid && in_ready;

  assign dispatch_ok = has_head && rob_ready && !flush;
  assign alu_valid   = dispatch_ok && (head_class == FU_ALU);
  assign mem_valid   = dispatch_ok && (head_class == FU_MEM);
  assign br_valid    = dispatch_ok && (head_class == FU_BR);

  assign fire = (alu_valid && alu_ready) || (mem_valid && mem_ready) ||
                (br_valid && br_ready);
  assign drop = has_head && (head_class == FU_NONE) && !flush;
  assign pop  = fire || drop;

  assign out_bundle = head_bundle;
  assign out_tag    = tag_q;
  assign illegal    = illegal_q;

  // Tag allocation: flush reloads, each real dispatch advances modulo ROB_DEPTH.
  always_comb begin
    tag_d     = tag_q;
    illegal_d = drop;
    alive_d   = 1'b1;
    if (flush) begin
      tag_d = flush_tag;
    end else if (fire) begin
      tag_d = (tag_q == TAG_LAST) ? '0 : tag_q + TAG_W'(1);
    end
  end

  // Registered tag counter, illegal pulse and post-reset enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= '0;
      illegal_q <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      illegal_q <= illegal_d;
      alive_q   <= alive_d;
    end
  end

endmodule

// File: tb/tb_dispatch_router.sv
// Directed self-checking bench for dispatch_router.
module tb_dispatch_router;
  import dispatch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  dec_bundle_t in_bundle;
  logic        rob_ready;
  logic        alu_valid, mem_valid, br_valid;
  logic        alu_ready, mem_ready, br_ready;
  dec_bundle_t out_bundle;
  logic [3:0]  out_tag;
  logic        flush;
  logic [3:0]  flush_tag;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  dispatch_router #(.ROB_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bundle  (in_bundle),
    .rob_ready  (rob_ready),
    .alu_valid  (alu_valid),
    .mem_valid  (mem_valid),
    .br_valid   (br_valid),
    .alu_ready  (alu_ready),
    .mem_ready  (mem_ready),
    .br_ready   (br_ready),
    .out_bundle (out_bundle),
    .out_tag    (out_tag),
    .flush      (flush),
    .flush_tag  (flush_tag),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic dec_bundle_t mk(input logic [6:0] op, input logic a,
                                     input logic m, input logic b,
                                     input logic [31:0] pc);
    dec_bundle_t d;
    d = '0;
    d.opcode = op;
    d.rd     = pc[6:2];
    d.fu_alu = a;
    d.fu_mem = m;
    d.fu_br  = b;
    d.pc     = pc;
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid  = 1'b0;
    in_bundle = '0;
    rob_ready = 1'b1;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    br_ready  = 1'b0;
    flush     = 1'b0;
    flush_tag = 4'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #7;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 0", in_ready); end
    checks++;
    if ({alu_valid, mem_valid, br_valid, illegal} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_valids got %b expected 0000", {alu_valid, mem_valid, br_valid, illegal});
    end
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_alu;
    dec_bundle_t add;
    do_reset();
    add = mk(OP_REG, 1, 0, 0, 32'h0000_0040);
    in_valid = 1'b1; in_bundle = add; alu_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL alu_no_bypass got %b expected 0", alu_valid); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b100) begin
      errors++; $display("[TB] FAIL alu_valids got %b expected 100", {alu_valid, mem_valid, br_valid});
    end
    checks++;
    if (out_tag !== 4'd0) begin errors++; $display("[TB] FAIL alu_tag got %0d expected 0", out_tag); end
    checks++;
    if (out_bundle !== add) begin errors++; $display("[TB] FAIL alu_bundle got pc %h expected pc %h", out_bundle.pc, add.pc); end
    tick();
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL alu_empty_after got %b expected 000", {alu_valid, mem_valid, br_valid});
    end
    // second op must carry the advanced tag
    in_valid = 1'b1; in_bundle = mk(OP_IMM, 1, 0, 0, 32'h44);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1 || out_tag !== 4'd1) begin
      errors++; $display("[TB] FAIL alu_tag_advance got valid %b tag %0d expected 1 tag 1", alu_valid, out_tag);
    end
    tick();
  endtask

  task automatic test_mem_br;
    dec_bundle_t sw, bne;
    do_reset();
    sw  = mk(OP_STORE, 1, 1, 0, 32'h100);
    bne = mk(OP_BRANCH, 1, 0, 1, 32'h104);
    alu_ready = 1'b1; mem_ready = 1'b1; br_ready = 1'b1;
    in_valid = 1'b1; in_bundle = sw;
    tick();
    in_bundle = bne;
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b010 || out_tag !== 4'd0 || out_bundle !== sw) begin
      errors++; $display("[TB] FAIL store_to_mem got v=%b tag %0d pc %h expected v=010 tag 0 pc %h",
                         {alu_valid, mem_valid, br_valid}, out_tag, out_bundle.pc, sw.pc);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b001 || out_tag !== 4'd1 || out_bundle !== bne) begin
      errors++; $display("[TB] FAIL branch_to_br got v=%b tag %0d pc %h expected v=001 tag 1 pc %h",
                         {alu_valid, mem_valid, br_valid}, out_tag, out_bundle.pc, bne.pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL mem_br_drained got %b expected 000", {alu_valid, mem_valid, br_valid});
    end
  endtask

  task automatic test_back_to_back;
    dec_bundle_t a0, a1, a2;
    do_reset();
    a0 = mk(OP_REG, 1, 0, 0, 32'h200);
    a1 = mk(OP_IMM, 1, 0, 0, 32'h204);
    a2 = mk(OP_LUI, 1, 0, 0, 32'h208);
    in_valid = 1'b1; in_bundle = a0;
    tick();
    in_bundle = a1;
    tick();
    in_bundle = a2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready got %b expected 0", in_ready); end
    tick();
    alu_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || alu_valid !== 1'b1 || out_tag !== 4'd0 || out_bundle !== a0) begin
      errors++; $display("[TB] FAIL b2b_first got rdy %b v %b tag %0d pc %h expected rdy 0 v 1 tag 0 pc %h",
                         in_ready, alu_valid, out_tag, out_bundle.pc, a0.pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || alu_valid !== 1'b1 || out_tag !== 4'd1 || out_bundle !== a1) begin
      errors++; $display("[TB] FAIL b2b_second got rdy %b v %b tag %0d pc %h expected rdy 1 v 1 tag 1 pc %h",
                         in_ready, alu_valid, out_tag, out_bundle.pc, a1.pc);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1 || out_tag !== 4'd2 || out_bundle !== a2) begin
      errors++; $display("[TB] FAIL b2b_third got v %b tag %0d pc %h expected v 1 tag 2 pc %h",
                         alu_valid, out_tag, out_bundle.pc, a2.pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got %b expected 0", alu_valid); end
  endtask

  task automatic test_rob_stall_illegal;
    dec_bundle_t a, bad;
    do_reset();
    a   = mk(OP_REG, 1, 0, 0, 32'h300);
    bad = mk(7'b1111111, 0, 0, 0, 32'h304);
    alu_ready = 1'b1; rob_ready = 1'b0;
    in_valid = 1'b1; in_bundle = a;
    tick();
    in_bundle = bad;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b0 || illegal !== 1'b0) begin
        errors++; $display("[TB] FAIL rob_stall cycle %0d got v %b ill %b expected 0 0", i, alu_valid, illegal);
      end
      tick();
    end
    rob_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1 || out_tag !== 4'd0 || out_bundle !== a) begin
      errors++; $display("[TB] FAIL stall_release got v %b tag %0d pc %h expected v 1 tag 0 pc %h",
                         alu_valid, out_tag, out_bundle.pc, a.pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid, illegal} !== 4'b0000) begin
      errors++; $display("[TB] FAIL none_head got %b expected 0000", {alu_valid, mem_valid, br_valid, illegal});
    end
    tick();
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse got %b expected 1", illegal); end
    tick();
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_single got %b expected 0", illegal); end
    in_valid = 1'b1; in_bundle = mk(OP_REG, 1, 0, 0, 32'h308);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1 || out_tag !== 4'd1) begin
      errors++; $display("[TB] FAIL drop_no_tag got v %b tag %0d expected v 1 tag 1", alu_valid, out_tag);
    end
    tick();
  endtask

  task automatic test_tag_wrap;
    dec_bundle_t x, y;
    do_reset();
    x = mk(OP_REG, 1, 0, 0, 32'h400);
    y = mk(OP_JALR, 1, 0, 0, 32'h404);
    flush = 1'b1; flush_tag = 4'd15;
    tick();
    flush = 1'b0;
    alu_ready = 1'b1;
    in_valid = 1'b1; in_bundle = x;
    tick();
    in_bundle = y;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1 || out_tag !== 4'd15) begin
      errors++; $display("[TB] FAIL wrap_first got v %b tag %0d expected v 1 tag 15", alu_valid, out_tag);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1 || out_tag !== 4'd0 || out_bundle !== y) begin
      errors++; $display("[TB] FAIL wrap_second got v %b tag %0d pc %h expected v 1 tag 0 pc %h",
                         alu_valid, out_tag, out_bundle.pc, y.pc);
    end
    tick();
  endtask

  task automatic test_flush;
    dec_bundle_t z;
    do_reset();
    z = mk(OP_LOAD, 1, 1, 0, 32'h508);
    in_valid = 1'b1; in_bundle = mk(OP_REG, 1, 0, 0, 32'h500);
    tick();
    in_bundle = mk(OP_REG, 1, 0, 0, 32'h504);
    tick();
    flush = 1'b1; flush_tag = 4'd9; alu_ready = 1'b1; mem_ready = 1'b1;
    in_bundle = mk(OP_REG, 1, 0, 0, 32'h5FC);
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b000 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_cycle got v %b rdy %b expected 000 0", {alu_valid, mem_valid, br_valid}, in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b000 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_empty got v %b rdy %b expected 000 1", {alu_valid, mem_valid, br_valid}, in_ready);
    end
    in_valid = 1'b1; in_bundle = z;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || out_tag !== 4'd9 || out_bundle !== z) begin
      errors++; $display("[TB] FAIL flush_tag got v %b tag %0d pc %h expected v 1 tag 9 pc %h",
                         mem_valid, out_tag, out_bundle.pc, z.pc);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    in_valid = 1'b1; in_bundle = mk(OP_REG, 1, 0, 0, 32'h600);
    tick();
    in_bundle = mk(OP_REG, 1, 0, 0, 32'h604);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre got %b expected 1", alu_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (alu_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_drop got v %b rdy %b expected 0 0", alu_valid, in_ready);
    end
    #10;
    rst_n = 1'b1;
    alu_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({alu_valid, mem_valid, br_valid} !== 3'b000 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_discard got v %b rdy %b expected 000 1", {alu_valid, mem_valid, br_valid}, in_ready);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_alu();
    test_mem_br();
    test_back_to_back();
    test_rob_stall_illegal();
    test_tag_wrap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
